// File: rtl/sparse_pack_if.sv
// Handshake bundle for sparse_pack: the vector input channel and the packed word output channel.
interface sparse_pack_if #(
    parameter int P     = 64,
    parameter int LANES = 8
);
    localparam int BW = $clog2(LANES + 1);

    logic                 in_valid;
    logic                 in_ready;
    logic [P*8-1:0]       in_data;
    logic [P-1:0]         in_nonz;

    logic                 out_valid;
    logic                 out_ready;
    logic [LANES*8-1:0]   out_data;
    logic                 out_kind;
    logic [BW-1:0]        out_bytes;
    logic                 out_last;

    // Producer/consumer side (drives vectors in, accepts words out)
    modport master (
        output in_valid, in_data, in_nonz, out_ready,
        input  in_ready, out_valid, out_data, out_kind, out_bytes, out_last
    );

    // Packer side
    modport slave (
        input  in_valid, in_data, in_nonz, out_ready,
        output in_ready, out_valid, out_data, out_kind, out_bytes, out_last
    );
endinterface

// File: rtl/sparse_pack.sv
// Sparse vector packer: emits the nonzero mask as H header words, then the flagged
// bytes packed LANES per word in ascending element order.
module sparse_pack #(
    parameter int P     = 64,
    parameter int LANES = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    sparse_pack_if.slave  bus,
    output logic [15:0]   vec_count
);
    localparam int W  = 8 * LANES;
    localparam int H  = P / W;
    localparam int BW = $clog2(LANES + 1);
    localparam int HW = (H > 1) ? $clog2(H) : 1;
    localparam int IW = $clog2(P);
    localparam logic [P-1:0] BIT0 = {{(P-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {IDLE, HDR, SCAN, EMIT} state_t;

    state_t           state_q, state_d;
    logic [P-1:0]     mask_q, mask_d;
    logic [BW-1:0]    fill_q, fill_d;
    logic [HW-1:0]    hdr_idx_q, hdr_idx_d;
    logic [15:0]      vec_count_q, vec_count_d;
    logic [P*8-1:0]   data_q;
    logic [W-1:0]     buf_q;

    logic             cap;
    logic             buf_wr;
    logic             buf_clr;
    logic [IW-1:0]    sel_idx;
    logic [7:0]       sel_byte;
    logic [P-1:0]     mask_clr;
    logic             hdr_last;

    logic             in_ready;
    logic             out_valid;
    logic [W-1:0]     out_data;
    logic             out_kind;
    logic [BW-1:0]    out_bytes;
    logic             out_last;

    // Lowest set bit wins, so bytes leave in ascending element order.
    function automatic logic [IW-1:0] lowest_set(input logic [P-1:0] m);
        logic [IW-1:0] idx;
        idx = '0;
        for (int i = P - 1; i >= 0; i--) begin
            if (m[i]) idx = IW'(i);
        end
        return idx;
    endfunction

    // in_nonz is bit-reversed relative to element order.
    function automatic logic [P-1:0] unreverse(input logic [P-1:0] nz);
        logic [P-1:0] m;
        for (int i = 0; i < P; i++) begin
            m[i] = nz[P-1-i];
        end
        return m;
    endfunction

    assign sel_idx  = lowest_set(mask_q);
    assign sel_byte = data_q[{sel_idx, 3'b000} +: 8];
    assign mask_clr = mask_q & ~(BIT0 << sel_idx);
    assign hdr_last = (hdr_idx_q == HW'(H - 1));

    // Control state: cleared asynchronously so a reset discards any vector in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            mask_q      <= '0;
            fill_q      <= '0;
            hdr_idx_q   <= '0;
            vec_count_q <= '0;
        end else begin
            state_q     <= state_d;
            mask_q      <= mask_d;
            fill_q      <= fill_d;
            hdr_idx_q   <= hdr_idx_d;
            vec_count_q <= vec_count_d;
        end
    end

    // Datapath: captured vector and the output byte buffer (unused bytes kept at zero).
    always_ff @(posedge clk) begin
        if (cap) data_q <= bus.in_data;
        if (cap || buf_clr) begin
            buf_q <= '0;
        end else if (buf_wr) begin
            buf_q[{fill_q, 3'b000} +: 8] <= sel_byte;
        end
    end

    // Next-state and output decode; outputs depend only on registered state.
    always_comb begin
        state_d     = state_q;
        mask_d      = mask_q;
        fill_d      = fill_q;
        hdr_idx_d   = hdr_idx_q;
        vec_count_d = vec_count_q;
        cap         = 1'b0;
        buf_wr      = 1'b0;
        buf_clr     = 1'b0;
        in_ready    = 1'b0;
        out_valid   = 1'b0;
        out_data    = '0;
        out_kind    = 1'b0;
        out_bytes   = '0;
        out_last    = 1'b0;

        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (bus.in_valid) begin
                    cap       = 1'b1;
                    mask_d    = unreverse(bus.in_nonz);
                    fill_d    = '0;
                    hdr_idx_d = '0;
                    state_d   = HDR;
                end
            end
            HDR: begin
                out_valid = 1'b1;
                out_data  = mask_q[hdr_idx_q * W +: W];
                out_bytes = BW'(LANES);
                out_last  = hdr_last && (mask_q == '0);
                if (bus.out_ready) begin
                    if (!hdr_last) begin
                        hdr_idx_d = hdr_idx_q + HW'(1);
                    end else if (mask_q == '0) begin
                        state_d     = IDLE;
                        vec_count_d = vec_count_q + 16'd1;
                    end else begin
                        state_d = SCAN;
                    end
                end
            end
            SCAN: begin
                buf_wr = 1'b1;
                mask_d = mask_clr;
                fill_d = fill_q + BW'(1);
                if ((fill_q + BW'(1) == BW'(LANES)) || (mask_clr == '0)) begin
                    state_d = EMIT;
                end
            end
            EMIT: begin
                out_valid = 1'b1;
                out_kind  = 1'b1;
                out_data  = buf_q;
                out_bytes = fill_q;
                out_last  = (mask_q == '0);
                if (bus.out_ready) begin
                    fill_d  = '0;
                    buf_clr = 1'b1;
                    if (mask_q != '0) begin
                        state_d = SCAN;
                    end else begin
                        state_d     = IDLE;
                        vec_count_d = vec_count_q + 16'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid;
    assign bus.out_data  = out_data;
    assign bus.out_kind  = out_kind;
    assign bus.out_bytes = out_bytes;
    assign bus.out_last  = out_last;
    assign vec_count     = vec_count_q;
endmodule

// File: tb/tb_sparse_pack.sv
// Directed bench for sparse_pack (P=64, LANES=8): table of single-word vectors plus
// hand sequences for full vectors, back-pressure, mid-vector reset and counter wrap.
module tb_sparse_pack;
    localparam int LIMIT = 400;

    logic        clk;
    logic        rst_n;
    logic [15:0] vec_count;

    sparse_pack_if #(.P(64), .LANES(8)) bus ();

    sparse_pack #(.P(64), .LANES(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .vec_count (vec_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    logic        wk [16];
    logic [3:0]  wb [16];
    logic        wl [16];
    logic [63:0] wd [16];

    typedef struct {
        int          np;
        int          i0, i1, i2, i3;
        logic [7:0]  v0, v1, v2, v3;
        logic [63:0] nz;
        logic [63:0] hdr;
        logic [63:0] dw;
        int          db;
    } vec_t;

    vec_t tbl [5];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_word(input string tag, input int j, input logic k, input logic [3:0] b,
                            input logic l, input logic [63:0] dta);
        check($sformatf("%s_w%0d_kind", tag, j), 128'(wk[j]), 128'(k));
        check($sformatf("%s_w%0d_bytes", tag, j), 128'(wb[j]), 128'(b));
        check($sformatf("%s_w%0d_last", tag, j), 128'(wl[j]), 128'(l));
        check($sformatf("%s_w%0d_data", tag, j), 128'(wd[j]), 128'(dta));
    endtask

    // Offer one vector, then collect every accepted output word until in_ready returns.
    task automatic run_vec(input logic [511:0] d, input logic [63:0] nz, input bit stall,
                           output int nw, output int cyc);
        logic [127:0] snap;
        logic [127:0] held;
        bit           pend;
        nw = 0;
        cyc = 0;
        pend = 1'b0;
        held = '0;
        for (int i = 0; i < 16; i++) begin
            wk[i] = 1'bx; wb[i] = 'x; wl[i] = 1'bx; wd[i] = 'x;
        end
        @(negedge clk);
        bus.in_data   = d;
        bus.in_nonz   = nz;
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        while (!bus.in_ready && cyc < LIMIT) begin
            if (stall) bus.out_ready = (cyc % 4 == 1) ? 1'b0 : 1'($urandom_range(0, 1));
            snap = {57'd0, bus.out_valid, bus.out_kind, bus.out_bytes, bus.out_last, bus.out_data};
            if (pend) check("stall_hold", snap, held);
            pend = 1'b0;
            if (bus.out_valid) begin
                if (bus.out_ready) begin
                    if (nw < 16) begin
                        wk[nw] = bus.out_kind;
                        wb[nw] = bus.out_bytes;
                        wl[nw] = bus.out_last;
                        wd[nw] = bus.out_data;
                    end
                    nw++;
                end else begin
                    pend = 1'b1;
                    held = snap;
                end
            end
            cyc++;
            @(negedge clk);
        end
        bus.out_ready = 1'b1;
        check("drain_bound", 128'(cyc < LIMIT), 128'd1);
    endtask

    initial begin
        logic [511:0] d;
        logic [63:0]  exp_w;
        logic [15:0]  exp_vc;
        int           nw;
        int           cyc;
        int           n;

        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.in_nonz   = '0;
        bus.out_ready = 1'b1;
        exp_vc        = 16'd0;

        // Reset state
        #12;
        check("rst_in_ready", 128'(bus.in_ready), 128'd1);
        check("rst_out_valid", 128'(bus.out_valid), 128'd0);
        check("rst_out_data", 128'(bus.out_data), 128'd0);
        check("rst_out_kind", 128'(bus.out_kind), 128'd0);
        check("rst_out_bytes", 128'(bus.out_bytes), 128'd0);
        check("rst_out_last", 128'(bus.out_last), 128'd0);
        check("rst_vec_count", 128'(vec_count), 128'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Table: vectors with at most LANES nonzeros; unflagged bytes are 0xEE filler
        tbl[0] = '{0, 0, 0, 0, 0, 8'h00, 8'h00, 8'h00, 8'h00,
                   64'h0, 64'h0, 64'h0, 0};
        tbl[1] = '{3, 3, 10, 63, 0, 8'h11, 8'h22, 8'h33, 8'h00,
                   64'h1020_0000_0000_0001, 64'h8000_0000_0000_0408, 64'h0000_0000_0033_2211, 3};
        tbl[2] = '{1, 0, 0, 0, 0, 8'hAB, 8'h00, 8'h00, 8'h00,
                   64'h8000_0000_0000_0000, 64'h1, 64'hAB, 1};
        tbl[3] = '{3, 5, 6, 7, 0, 8'h00, 8'h77, 8'h5A, 8'h00,
                   64'h0600_0000_0000_0000, 64'h60, 64'h7700, 2};
        tbl[4] = '{4, 1, 2, 40, 62, 8'h01, 8'h02, 8'h28, 8'h3E,
                   64'h6000_0000_0080_0002, 64'h4000_0100_0000_0006, 64'h3E28_0201, 4};

        for (int t = 0; t < 5; t++) begin
            d = {64{8'hEE}};
            if (tbl[t].np > 0) d[tbl[t].i0*8 +: 8] = tbl[t].v0;
            if (tbl[t].np > 1) d[tbl[t].i1*8 +: 8] = tbl[t].v1;
            if (tbl[t].np > 2) d[tbl[t].i2*8 +: 8] = tbl[t].v2;
            if (tbl[t].np > 3) d[tbl[t].i3*8 +: 8] = tbl[t].v3;
            run_vec(d, tbl[t].nz, 1'b0, nw, cyc);
            exp_vc = exp_vc + 16'd1;
            check($sformatf("tbl%0d_nwords", t), 128'(nw), 128'(1 + ((tbl[t].db != 0) ? 1 : 0)));
            chk_word($sformatf("tbl%0d", t), 0, 1'b0, 4'd8, (tbl[t].db == 0), tbl[t].hdr);
            if (tbl[t].db != 0) chk_word($sformatf("tbl%0d", t), 1, 1'b1, 4'(tbl[t].db), 1'b1, tbl[t].dw);
            check($sformatf("tbl%0d_cycles", t), 128'(cyc),
                  128'(1 + tbl[t].db + ((tbl[t].db != 0) ? 1 : 0)));
            check($sformatf("tbl%0d_vec_count", t), 128'(vec_count), 128'(exp_vc));
        end

        // All 64 elements nonzero, value = index+1
        for (int i = 0; i < 64; i++) d[i*8 +: 8] = 8'(i + 1);
        run_vec(d, {64{1'b1}}, 1'b0, nw, cyc);
        exp_vc = exp_vc + 16'd1;
        check("full_nwords", 128'(nw), 128'd9);
        check("full_cycles", 128'(cyc), 128'd73);
        chk_word("full", 0, 1'b0, 4'd8, 1'b0, {64{1'b1}});
        for (int j = 1; j <= 8; j++) begin
            for (int k = 0; k < 8; k++) exp_w[k*8 +: 8] = 8'(8 * (j - 1) + k + 1);
            chk_word("full", j, 1'b1, 4'd8, (j == 8), exp_w);
        end
        check("full_last_word", 128'(wd[8]), 128'h403F_3E3D_3C3B_3A39);
        check("full_vec_count", 128'(vec_count), 128'(exp_vc));

        // 9 nonzeros (elements 0..8) under random back-pressure
        d = {64{8'hEE}};
        for (int i = 0; i < 9; i++) d[i*8 +: 8] = 8'h91 + 8'(i);
        run_vec(d, 64'hFF80_0000_0000_0000, 1'b1, nw, cyc);
        exp_vc = exp_vc + 16'd1;
        check("stall_nwords", 128'(nw), 128'd3);
        chk_word("stall", 0, 1'b0, 4'd8, 1'b0, 64'h1FF);
        chk_word("stall", 1, 1'b1, 4'd8, 1'b0, 64'h9897_9695_9493_9291);
        chk_word("stall", 2, 1'b1, 4'd1, 1'b1, 64'h99);
        check("stall_vec_count", 128'(vec_count), 128'(exp_vc));

        // Reset while a 20-nonzero vector is mid-flight (held in its first data word)
        @(negedge clk);
        d = '0;
        for (int i = 0; i < 20; i++) d[i*8 +: 8] = 8'h50 + 8'(i);
        bus.in_data   = d;
        bus.in_nonz   = 64'hFFFF_F000_0000_0000;
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        @(negedge clk);
        bus.out_ready = 1'b0;
        n = 0;
        while (!(bus.out_valid && bus.out_kind) && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("mid_reached_emit", 128'({bus.out_valid, bus.out_kind}), 128'd3);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_out_valid", 128'(bus.out_valid), 128'd0);
        check("mid_rst_in_ready", 128'(bus.in_ready), 128'd1);
        check("mid_rst_out_data", 128'(bus.out_data), 128'd0);
        check("mid_rst_out_bytes", 128'(bus.out_bytes), 128'd0);
        check("mid_rst_vec_count", 128'(vec_count), 128'd0);
        @(negedge clk);
        rst_n = 1'b1;
        bus.out_ready = 1'b1;
        exp_vc = 16'd0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("post_rst_quiet", 128'({bus.out_valid, bus.in_ready}), 128'd1);
        end
        d = {64{8'hEE}};
        d[3*8 +: 8]  = 8'h11;
        d[10*8 +: 8] = 8'h22;
        d[63*8 +: 8] = 8'h33;
        run_vec(d, 64'h1020_0000_0000_0001, 1'b0, nw, cyc);
        exp_vc = exp_vc + 16'd1;
        check("post_rst_nwords", 128'(nw), 128'd2);
        chk_word("post_rst", 0, 1'b0, 4'd8, 1'b0, 64'h8000_0000_0000_0408);
        chk_word("post_rst", 1, 1'b1, 4'd3, 1'b1, 64'h33_2211);
        check("post_rst_vec_count", 128'(vec_count), 128'(exp_vc));

        // Counter wrap: preload near the top, then two all-zero vectors
        @(negedge clk);
        force dut.vec_count_q = 16'hFFFE;
        @(posedge clk);
        @(negedge clk);
        release dut.vec_count_q;
        run_vec({64{8'hEE}}, 64'h0, 1'b0, nw, cyc);
        check("wrap_pre_top", 128'(vec_count), 128'hFFFF);
        run_vec({64{8'hEE}}, 64'h0, 1'b0, nw, cyc);
        check("wrap_to_zero", 128'(vec_count), 128'h0);
        check("wrap_zero_cycles", 128'(cyc), 128'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
